// File: rtl/led_shift_ctrl_pkg.sv
// rtl/led_shift_ctrl_pkg.sv - shared constants, state encoding and helpers for the LED shift sequencer
package led_shift_ctrl_pkg;

    localparam int LED_W_DEF = 8;
    localparam int PS_W_DEF  = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_TURN  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_TURN  = ST_TURN,
        S_DONE  = ST_DONE
    } state_t;

    // Sweep counter saturates so an endless run never wraps back onto a passes match.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step-rate prescaler: counts enabled cycles and ticks when the count matches the period
module led_prescaler
    import led_shift_ctrl_pkg::*;
#(
    parameter int W = PS_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] count;

    assign tick = en && (count == period);

    // Holding when disabled lets a paused sequence resume mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/led_shift_ctrl.sv
// rtl/led_shift_ctrl.sv - LED shift-light sequencer: step rate, sweep counting, ping-pong reversal and completion
module led_shift_ctrl
    import led_shift_ctrl_pkg::*;
#(
    parameter  int LED_W = LED_W_DEF,
    parameter  int PS_W  = PS_W_DEF,
    localparam int POS_W = $clog2(LED_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [PS_W-1:0]  prescale,
    input  logic [3:0]       passes,
    input  logic             auto_rev,
    input  logic             dir_init,
    output logic             led_ss,
    output logic             led_mode,
    output logic             led_load,
    output logic             led_step,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             done
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);

    state_t            state;
    state_t            nxt_state;
    logic              nxt_mode;

    logic [PS_W-1:0]   sh_prescale;
    logic [3:0]        sh_passes;
    logic              sh_auto_rev;

    logic [3:0]        sweep_cnt;
    logic              reversed;
    logic              pend;
    logic              pre_en;
    logic              pre_clr;
    logic              tick;

    // Target sweeps reached: the TURN/DONE decision stays pending across a PAUSE.
    assign pend    = (sh_passes != 4'd0) && (sweep_cnt == sh_passes);
    assign pre_en  = (state == S_RUN) && !pend;
    assign pre_clr = (nxt_state == S_LOAD) || (nxt_state == S_TURN);

    led_prescaler #(.W(PS_W)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pre_en),
        .clr    (pre_clr),
        .period (sh_prescale),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_mode  = led_mode;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_state = S_LOAD;
                end
            end
            S_LOAD: begin
                nxt_state = S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    nxt_state = S_PAUSE;
                end else if (pend) begin
                    nxt_state = (sh_auto_rev && !reversed) ? S_TURN : S_DONE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    nxt_state = S_IDLE;
                end else if (start) begin
                    nxt_state = S_RUN;
                end
            end
            S_TURN: begin
                nxt_state = stop ? S_PAUSE : S_RUN;
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        if ((state == S_IDLE) || (nxt_state == S_IDLE)) begin
            nxt_mode = dir_init;
        end else if (nxt_state == S_TURN) begin
            nxt_mode = ~led_mode;
        end
    end

    // Outputs are registered from next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_ss   <= 1'b0;
            led_mode <= 1'b0;
            led_load <= 1'b0;
            led_step <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            led_ss   <= (nxt_state == S_RUN);
            led_mode <= nxt_mode;
            led_load <= (nxt_state == S_LOAD) || (nxt_state == S_TURN);
            led_step <= tick;
            busy     <= (nxt_state != S_IDLE);
            done     <= (nxt_state == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_prescale <= '0;
            sh_passes   <= 4'd0;
            sh_auto_rev <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            sh_prescale <= prescale;
            sh_passes   <= passes;
            sh_auto_rev <= auto_rev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos       <= '0;
            sweep_cnt <= 4'd0;
        end else if (pre_clr) begin
            pos       <= '0;
            sweep_cnt <= 4'd0;
        end else if (tick) begin
            pos <= pos + POS_W'(1);
            if (pos == POS_LAST) begin
                sweep_cnt <= sat_inc4(sweep_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reversed <= 1'b0;
        end else if (nxt_state == S_LOAD) begin
            reversed <= 1'b0;
        end else if (nxt_state == S_TURN) begin
            reversed <= 1'b1;
        end
    end

endmodule
